// File: rtl/range_frame_sender_if.sv
// range_frame_sender_if
// Host-side and burst-side signals of the range frame sender in one bundle.
//   master : the host / test driver. It drives wr_data, wr_valid and send and
//            observes everything else.
//   slave  : the range_frame_sender itself.
// Signals:
//   wr_data/wr_valid/wr_ready : sample load handshake
//   send                      : start playback of the buffered frame
//   data_out/go/finish        : framed burst towards the range finder
//   busy                      : frame in progress (SEND or DONE)
//   exp_valid/exp_range       : expected max - min of the frame just sent
//   error                     : send requested with an empty buffer
interface range_frame_sender_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             send;
  logic [WIDTH-1:0] data_out;
  logic             go;
  logic             finish;
  logic             busy;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_range;
  logic             error;

  modport master (
    output wr_data, wr_valid, send,
    input  wr_ready, data_out, go, finish, busy, exp_valid, exp_range, error
  );

  modport slave (
    input  wr_data, wr_valid, send,
    output wr_ready, data_out, go, finish, busy, exp_valid, exp_range, error
  );
endinterface

// File: rtl/range_frame_sender.sv
// range_frame_sender
// Buffers up to DEPTH host samples and, on send, plays them out as one framed
// burst (go on the first sample, finish on the last), one sample per cycle.
// The running min/max of the loaded samples yields the expected range, which
// is published with a one-cycle exp_valid pulse after the last sample.
// Ports:
//   clock   : single rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : range_frame_sender_if slave modport (see interface header)
// All outputs except wr_ready are registered.
module range_frame_sender #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  range_frame_sender_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    remaining_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [WIDTH-1:0] data_out_r;
  logic             go_r;
  logic             finish_r;
  logic             busy_r;
  logic             exp_valid_r;
  logic [WIDTH-1:0] exp_range_r;
  logic             error_r;

  logic             wr_ready_s;
  logic             write_en_s;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] min_next_s;
  logic [WIDTH-1:0] max_next_s;
  logic [WIDTH-1:0] first_sample_s;

  assign wr_ready_s    = (state_r == IDLE) && (count_r < CW'(DEPTH));
  assign bus.wr_ready  = wr_ready_s;
  assign bus.data_out  = data_out_r;
  assign bus.go        = go_r;
  assign bus.finish    = finish_r;
  assign bus.busy      = busy_r;
  assign bus.exp_valid = exp_valid_r;
  assign bus.exp_range = exp_range_r;
  assign bus.error     = error_r;

  // Next-state view of the buffer for the current cycle's write (if any).
  always_comb begin
    write_en_s     = bus.wr_valid && wr_ready_s;
    count_next_s   = count_r;
    min_next_s     = min_r;
    max_next_s     = max_r;
    first_sample_s = mem_r[{AW{1'b0}}];
    if (write_en_s) begin
      count_next_s = count_r + CW'(1'b1);
      // The first word of a frame seeds both extremes.
      if (count_r == {CW{1'b0}}) begin
        min_next_s = bus.wr_data;
        max_next_s = bus.wr_data;
      end else begin
        min_next_s = (bus.wr_data < min_r) ? bus.wr_data : min_r;
        max_next_s = (bus.wr_data > max_r) ? bus.wr_data : max_r;
      end
    end else begin
      count_next_s = count_r;
    end
    // A word written in the same cycle as send is not in mem_r yet; when the
    // buffer was empty it is the first sample and must be bypassed.
    if (count_r == {CW{1'b0}}) begin
      first_sample_s = bus.wr_data;
    end else begin
      first_sample_s = mem_r[{AW{1'b0}}];
    end
  end

  // Sample storage; contents need no reset since count_r gates their use.
  always_ff @(posedge clock) begin
    if (write_en_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Control FSM with registered burst and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      remaining_r <= {CW{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      min_r       <= {WIDTH{1'b0}};
      max_r       <= {WIDTH{1'b0}};
      data_out_r  <= {WIDTH{1'b0}};
      go_r        <= 1'b0;
      finish_r    <= 1'b0;
      busy_r      <= 1'b0;
      exp_valid_r <= 1'b0;
      exp_range_r <= {WIDTH{1'b0}};
      error_r     <= 1'b0;
    end else begin
      exp_valid_r <= 1'b0;
      error_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          count_r <= count_next_s;
          min_r   <= min_next_s;
          max_r   <= max_next_s;
          if (write_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
          end
          if (bus.send) begin
            if (count_next_s == {CW{1'b0}}) begin
              error_r <= 1'b1;
            end else begin
              state_r     <= SEND;
              data_out_r  <= first_sample_s;
              go_r        <= 1'b1;
              finish_r    <= (count_next_s == CW'(1'b1));
              busy_r      <= 1'b1;
              rd_ptr_r    <= AW'(1'b1);
              remaining_r <= count_next_s;
            end
          end
        end
        SEND: begin
          // remaining_r counts the sample on data_out plus those still to go.
          if (remaining_r == CW'(1'b1)) begin
            state_r     <= DONE;
            data_out_r  <= {WIDTH{1'b0}};
            go_r        <= 1'b0;
            finish_r    <= 1'b0;
            remaining_r <= {CW{1'b0}};
            exp_valid_r <= 1'b1;
            exp_range_r <= max_r - min_r;
          end else begin
            data_out_r  <= mem_r[rd_ptr_r];
            go_r        <= 1'b0;
            finish_r    <= (remaining_r == CW'(2'd2));
            rd_ptr_r    <= rd_ptr_r + AW'(1'b1);
            remaining_r <= remaining_r - CW'(1'b1);
          end
        end
        DONE: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          count_r  <= {CW{1'b0}};
          wr_ptr_r <= {AW{1'b0}};
          rd_ptr_r <= {AW{1'b0}};
          min_r    <= {WIDTH{1'b0}};
          max_r    <= {WIDTH{1'b0}};
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= {CW{1'b0}};
          remaining_r <= {CW{1'b0}};
          wr_ptr_r    <= {AW{1'b0}};
          rd_ptr_r    <= {AW{1'b0}};
          data_out_r  <= {WIDTH{1'b0}};
          go_r        <= 1'b0;
          finish_r    <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_sender.sv
// tb_range_frame_sender
// Self-checking bench for range_frame_sender (WIDTH=10, DEPTH=8).
// A queue holds the words the host has successfully loaded; frames, go/finish
// placement and the expected range are derived from that queue.
module tb_range_frame_sender;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;

  logic clock;
  logic reset_n;

  range_frame_sender_if #(.WIDTH(WIDTH)) bus ();

  range_frame_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] model_q [$];

  typedef struct {
    int               n;
    logic [3:0][9:0]  w;
    logic [9:0]       rng;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one word for one cycle; the model decides whether it fits.
  task automatic load(input logic [WIDTH-1:0] v);
    bus.wr_data  = v;
    bus.wr_valid = 1'b1;
    chk("wr_ready", bus.wr_ready, (model_q.size() < DEPTH));
    if (model_q.size() < DEPTH) model_q.push_back(v);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Pulse send (optionally with a same-cycle write), then check the whole
  // burst and the range report. jam holds wr_valid=0x0AA during the burst.
  task automatic send_frame(input bit with_write, input logic [WIDTH-1:0] wv,
                            input bit jam, output logic [WIDTH-1:0] got_range);
    int n;
    logic [WIDTH-1:0] mn, mx;
    got_range = '0;
    if (with_write) begin
      bus.wr_data  = wv;
      bus.wr_valid = 1'b1;
      chk("wr_ready_send", bus.wr_ready, (model_q.size() < DEPTH));
      if (model_q.size() < DEPTH) model_q.push_back(wv);
    end
    bus.send = 1'b1;
    tick();
    bus.send     = 1'b0;
    bus.wr_valid = 1'b0;
    n = model_q.size();
    if (n == 0) begin
      chk("error_pulse", bus.error, 1);
      chk("error_go", bus.go, 0);
      chk("error_busy", bus.busy, 0);
      tick();
      chk("error_once", bus.error, 0);
      chk("error_wr_ready", bus.wr_ready, 1);
      return;
    end
    mn = model_q[0];
    mx = model_q[0];
    foreach (model_q[i]) begin
      if (model_q[i] < mn) mn = model_q[i];
      if (model_q[i] > mx) mx = model_q[i];
    end
    for (int i = 0; i < n; i++) begin
      if (jam) begin
        bus.wr_data  = 10'h0AA;
        bus.wr_valid = 1'b1;
      end
      chk("data_out", bus.data_out, model_q[i]);
      chk("go", bus.go, (i == 0));
      chk("finish", bus.finish, (i == n - 1));
      chk("busy_send", bus.busy, 1);
      chk("wr_ready_send", bus.wr_ready, 0);
      chk("exp_valid_early", bus.exp_valid, 0);
      if (i == 0) chk("error_none", bus.error, 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("exp_valid", bus.exp_valid, 1);
    chk("exp_range", bus.exp_range, mx - mn);
    chk("data_out_done", bus.data_out, 0);
    chk("busy_done", bus.busy, 1);
    chk("wr_ready_done", bus.wr_ready, 0);
    got_range = bus.exp_range;
    tick();
    chk("exp_valid_once", bus.exp_valid, 0);
    chk("exp_range_held", bus.exp_range, mx - mn);
    chk("busy_idle", bus.busy, 0);
    chk("wr_ready_idle", bus.wr_ready, 1);
    model_q.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] rng;

    tbl[0] = '{3, {10'd0, 10'd5, 10'd7, 10'd3}, 10'd4};
    tbl[1] = '{1, {10'd0, 10'd0, 10'd0, 10'h155}, 10'd0};
    tbl[2] = '{2, {10'd0, 10'd0, 10'h000, 10'h3FF}, 10'h3FF};
    tbl[3] = '{4, {10'h300, 10'h100, 10'h001, 10'h200}, 10'h2FF};
    tbl[4] = '{4, {10'd9, 10'd9, 10'd9, 10'd9}, 10'd0};

    reset_n      = 1'b0;
    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;
    bus.send     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_go", bus.go, 0);
    chk("rst_finish", bus.finish, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_exp_valid", bus.exp_valid, 0);
    chk("rst_exp_range", bus.exp_range, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    reset_n = 1'b1;
    tick();

    // Table-driven frames.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) load(tbl[t].w[i]);
      send_frame(1'b0, '0, 1'b0, rng);
      chk("tbl_range", rng, tbl[t].rng);
    end

    // Overflow: 9 words offered, only 8 kept.
    for (int i = 1; i <= 9; i++) load(10'(i));
    send_frame(1'b0, '0, 1'b0, rng);
    chk("full_range", rng, 10'd7);

    // Empty send, then a two-word frame.
    send_frame(1'b0, '0, 1'b0, rng);
    load(10'h3FF);
    load(10'h000);
    send_frame(1'b0, '0, 1'b0, rng);
    chk("extreme_range", rng, 10'h3FF);

    // Writes held during SEND are not accepted.
    for (int i = 0; i < 4; i++) load(10'(i + 20));
    send_frame(1'b0, '0, 1'b1, rng);
    load(10'd50);
    send_frame(1'b0, '0, 1'b0, rng);

    // Same-cycle write is the last sample; also single-sample via bypass.
    load(10'd1);
    load(10'd2);
    send_frame(1'b1, 10'h077, 1'b0, rng);
    chk("same_cycle_range", rng, 10'h076);
    send_frame(1'b1, 10'h123, 1'b0, rng);
    chk("bypass_range", rng, 10'd0);

    // Reset in the middle of a 5-sample frame.
    for (int i = 0; i < 5; i++) load(10'(100 + i));
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
    chk("pre_rst_go", bus.go, 1);
    tick();
    chk("pre_rst_data", bus.data_out, 10'd101);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_data_out", bus.data_out, 0);
    chk("mid_rst_go", bus.go, 0);
    chk("mid_rst_finish", bus.finish, 0);
    chk("mid_rst_busy", bus.busy, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_rst_exp_valid", bus.exp_valid, 0);
    end
    reset_n = 1'b1;
    tick();
    chk("post_rst_exp_valid", bus.exp_valid, 0);
    model_q.delete();
    send_frame(1'b0, '0, 1'b0, rng);

    // Randomized frames against the queue model.
    for (int it = 0; it < 25; it++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        load(10'($urandom_range(0, 1023)));
      end
      send_frame(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), rng);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_frame_sender.md
# range_frame_sender

Stimulus-side counterpart of the range finder. It buffers up to DEPTH samples written by a host, then, on command, plays them out as one framed burst on the range finder's input protocol: `data_out` carries the samples, `go` marks the first sample and `finish` marks the last. Alongside the burst it computes the expected range (max − min) of the frame, so on-chip self-test can compare it against the range finder's result. It sits between the host I/O pins and the range finder's `data_in`/`go`/`finish` inputs.

## Interface
- WIDTH, 10: sample width in bits.
- DEPTH, 8: buffer capacity in samples; power of two, ≥2.
- clock  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_data  in  WIDTH  sample to load.
- wr_valid  in  1  host offers `wr_data` this cycle.
- wr_ready  out  1  buffer accepts a word; combinational: (state==IDLE) && (count<DEPTH).
- send  in  1  start playback of the buffered frame; sampled in IDLE only.
- data_out  out  WIDTH  current frame sample; 0 when not sending.
- go  out  1  high with the first sample of a frame.
- finish  out  1  high with the last sample of a frame.
- busy  out  1  high in SEND and DONE.
- exp_valid  out  1  one-cycle pulse; `exp_range` is updated in that cycle.
- exp_range  out  WIDTH  max − min of the last frame sent; held between pulses.
- error  out  1  one-cycle pulse when `send` arrives with an empty buffer.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - A write occurs when wr_valid && wr_ready. The word goes to `buf[wr_ptr]`; `wr_ptr` and `count` increment.
  - Each write also updates the running min/max. The first word of a frame initialises both.
- IDLE + send:
  - count==0 (after any same-cycle write): `error` pulses next cycle; stay in IDLE.
  - Otherwise: go to SEND with `rd_ptr` = 0 and `remaining` = count.
  - A write accepted in the same cycle as `send` is part of the frame.
- SEND:
  - Each cycle outputs one sample in write order.
  - `go` = 1 on the first sample. `finish` = 1 when `remaining` == 1.
  - After the last sample, go to DONE.
  - `wr_ready` = 0; `wr_valid` and `send` are ignored.
- DONE (one cycle):
  - `exp_valid` = 1 and `exp_range` = max − min (unsigned, always ≥0, fits WIDTH).
  - Clear `count`, the pointers and the min/max tracking.
  - Return to IDLE.
- Single-sample frame: `go` and `finish` are both 1 in the same cycle.
- Full buffer: `wr_ready` = 0; offered words are dropped silently and the host must hold them.
- All outputs except `wr_ready` are registered.

## Timing
- Reset values:
  - state IDLE; count 0.
  - `data_out`, `go`, `finish`, `busy`, `exp_valid`, `error`, `exp_range` all 0.
  - `wr_ready` = 1.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). The buffer is emptied and no `exp_valid` pulse is produced.
- `send` sampled at edge t, frame of N samples:
  - Samples appear in cycles t+1 … t+N.
  - `go` in cycle t+1; `finish` in cycle t+N.
  - `exp_valid` in cycle t+N+1.
  - IDLE again in cycle t+N+2, when `wr_ready` may reassert.
- Throughput: one sample per cycle, no gaps within a frame.
- Error: `send` with an empty buffer at edge t gives `error` = 1 in cycle t+1 only.

## Test plan
- Load 3, 7, 5, then `send` → `data_out` = 3/7/5 on consecutive cycles; `go` only with 3, `finish` only with 5; next cycle `exp_valid` = 1 with `exp_range` = 4; `count` = 0 afterwards.
- Load only 0x155, then `send` → a single cycle with `data_out` = 0x155 and `go` = `finish` = 1; then `exp_range` = 0.
- DEPTH=8: offer 9 words (1..9) back-to-back → `wr_ready` drops after the 8th and 9 is not stored; `send` plays 1..8; `exp_range` = 7.
- `send` on an empty buffer → `error` high for exactly one cycle; `go`/`busy` stay 0. Then load 0x3FF, 0 and `send` → `exp_range` = 0x3FF.
- Hold `wr_valid` = 1 with 0x0AA during a 4-sample SEND → the word is not accepted; the next frame contains no 0x0AA. Separately, a write in the same cycle as `send` is played as the last sample.
- Assert `reset_n` = 0 after 2 of 5 samples → `data_out`/`go`/`finish`/`busy` are 0 immediately and no `exp_valid`. After release, `send` gives an `error` pulse (buffer empty).
